// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the MDU state enum, default MDU latencies and the zero register.
package pipe_ctrl_pkg;

   // Multiply/divide unit occupancy states
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // Default MDU latencies, in busy cycles after the start edge
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // $zero is hardwired, so it never creates a dependency
   localparam logic [4:0] ZERO_REG = 5'd0;

   // True when a source reads a real (nonzero) destination
   function automatic logic reg_hit(
      input logic [4:0] src,
      input logic [4:0] dst
   );
      return (src == dst) && (dst != ZERO_REG);
   endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks multi-cycle MDU occupancy with a two-state FSM and down-counter.
// Ports: clk, reset (async active-low), md_start, md_is_div -> md_busy.
module md_busy_tracker
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   md_state_e     state_q, state_d;
   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic          md_busy_q, md_busy_d;

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      unique case (state_q)
         MD_IDLE: begin
            if (md_start) begin
               md_cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
               state_d  = MD_BUSY;
            end
         end
         MD_BUSY: begin
            // A start here is illegal; the counter keeps running
            md_cnt_d = md_cnt_q - CNT_ONE;
            if (md_cnt_q == CNT_ONE) begin
               state_d = MD_IDLE;
            end
         end
         default: begin
            state_d  = MD_IDLE;
            md_cnt_d = '0;
         end
      endcase
      // Busy flag is registered alongside the state it mirrors
      md_busy_d = (state_d == MD_BUSY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= MD_IDLE;
         md_cnt_q  <= '0;
         md_busy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         md_cnt_q  <= md_cnt_d;
         md_busy_q <= md_busy_d;
      end
   end

   assign md_busy = md_busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use,
// branch-operand and MDU-wait hazards drive stall (PC, IF/ID) and
// bubble (ID/EX). Ports: ID sources/use flags, EX/MEM destinations,
// MDU start, outputs stall, bubble, md_busy, stall_cnt.
// Optional macro PIPE_STALL_CNT_EN enables the saturating stall counter;
// without it stall_cnt is tied to zero.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs_d,
   input  logic             id_use_rt_d,
   input  logic             id_use_rs_e,
   input  logic             id_use_rt_e,
   input  logic             id_is_md,
   input  logic [4:0]       ex_wa,
   input  logic             ex_wr_en,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_wa,
   input  logic             mem_is_load,
   input  logic             md_start,
   input  logic             md_is_div,
   output logic             stall,
   output logic             bubble,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   logic rs_ex, rt_ex, rs_mem, rt_mem;
   logic load_use, br_alu, br_load, md_haz;

   md_busy_tracker #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md (
      .clk       (clk),
      .reset     (reset),
      .md_start  (md_start),
      .md_is_div (md_is_div),
      .md_busy   (md_busy)
   );

   always_comb begin
      rs_ex  = reg_hit(id_rs, ex_wa);
      rt_ex  = reg_hit(id_rt, ex_wa);
      rs_mem = reg_hit(id_rs, mem_wa);
      rt_mem = reg_hit(id_rt, mem_wa);

      // Load data is not ready for either ID or EX consumers
      load_use = ex_is_load
               & ((rs_ex & (id_use_rs_d | id_use_rs_e))
               |  (rt_ex & (id_use_rt_d | id_use_rt_e)));

      // ALU result can reach EX by forwarding, but not a compare in ID
      br_alu = ex_wr_en & ~ex_is_load
             & ((rs_ex & id_use_rs_d) | (rt_ex & id_use_rt_d));

      // Load data arrives too late in MEM for an ID-stage compare
      br_load = mem_is_load
              & ((rs_mem & id_use_rs_d) | (rt_mem & id_use_rt_d));

      // Masked while reset is held so an aborted MDU cannot stall
      md_haz = id_is_md & (md_busy | md_start) & reset;

      stall  = load_use | br_alu | br_load | md_haz;
      bubble = stall;
   end

`ifdef PIPE_STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic compared against a cycle-timestamp model.
module tb_pipe_hazard_ctrl;

   localparam int MULT = 5;
   localparam int DIV  = 10;
   localparam int CW   = 32;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs, id_rt;
   logic          id_use_rs_d, id_use_rt_d, id_use_rs_e, id_use_rt_e;
   logic          id_is_md;
   logic [4:0]    ex_wa;
   logic          ex_wr_en, ex_is_load;
   logic [4:0]    mem_wa;
   logic          mem_is_load;
   logic          md_start, md_is_div;
   logic          stall, bubble, md_busy;
   logic [CW-1:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   pipe_hazard_ctrl #(
      .MULT_CYCLES (MULT),
      .DIV_CYCLES  (DIV),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs_d (id_use_rs_d),
      .id_use_rt_d (id_use_rt_d),
      .id_use_rs_e (id_use_rs_e),
      .id_use_rt_e (id_use_rt_e),
      .id_is_md    (id_is_md),
      .ex_wa       (ex_wa),
      .ex_wr_en    (ex_wr_en),
      .ex_is_load  (ex_is_load),
      .mem_wa      (mem_wa),
      .mem_is_load (mem_is_load),
      .md_start    (md_start),
      .md_is_div   (md_is_div),
      .stall       (stall),
      .bubble      (bubble),
      .md_busy     (md_busy),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // MDU occupancy is kept as "last busy cycle number".
   int     cyc       = 0;
   int     busy_last = -1;
   longint m_cnt     = 0;

   function automatic bit m_busy();
      return cyc <= busy_last;
   endfunction

   function automatic bit m_stall();
      bit h;
      h = 0;
      for (int s = 0; s < 2; s++) begin
         logic [4:0] r;
         bit ud, ue;
         r  = (s == 0) ? id_rs : id_rt;
         ud = (s == 0) ? id_use_rs_d : id_use_rt_d;
         ue = (s == 0) ? id_use_rs_e : id_use_rt_e;
         if (ex_is_load && ex_wa != 0 && r == ex_wa && (ud || ue)) h = 1;
         if (ex_wr_en && !ex_is_load && ex_wa != 0 && r == ex_wa && ud)
            h = 1;
         if (mem_is_load && mem_wa != 0 && r == mem_wa && ud) h = 1;
      end
      if (reset && id_is_md && (m_busy() || md_start)) h = 1;
      return h;
   endfunction

   function automatic longint exp_cnt();
`ifdef PIPE_STALL_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc       = 0;
         busy_last = -1;
         m_cnt     = 0;
      end else begin
         if (m_stall() && m_cnt != 64'hFFFF_FFFF) m_cnt++;
         if (md_start && !m_busy())
            busy_last = cyc + (md_is_div ? DIV : MULT);
         cyc++;
      end
   end

   task automatic chk(input string name, input longint got,
                      input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, got, exp, $time);
      end
   endtask

   // Continuous compare against the model
   always @(negedge clk) begin
      chk("stall", longint'(stall), longint'(m_stall()));
      chk("bubble", longint'(bubble), longint'(m_stall()));
      chk("md_busy", longint'(md_busy), longint'(m_busy()));
      chk("stall_cnt", longint'(stall_cnt), exp_cnt());
   end

   // ---------------- stimulus helpers ----------------
   task automatic clr();
      id_rs = 0; id_rt = 0;
      id_use_rs_d = 0; id_use_rt_d = 0;
      id_use_rs_e = 0; id_use_rt_e = 0;
      id_is_md = 0;
      ex_wa = 0; ex_wr_en = 0; ex_is_load = 0;
      mem_wa = 0; mem_is_load = 0;
      md_start = 0; md_is_div = 0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_evt();
      clr();
      ex_wa = 5; ex_wr_en = 1; ex_is_load = 1;
      id_rs = 5; id_rt = 1; id_use_rs_e = 1; id_use_rt_e = 1;
      @(negedge clk);
      chk("lu_stall", longint'(stall), 1);
      next();
      clr();
      next();
   endtask

   // Counts stall cycles of an MDU wait starting now
   task automatic md_wait(input bit div, output int n);
      clr();
      id_is_md = 1; md_start = 1; md_is_div = div;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
         next();
         md_start = 0;
      end
      next();
      clr();
   endtask

   int n;

   initial begin
      reset = 1'b0;
      clr();

      // Reset state; register terms live, MDU term masked
      ex_wa = 5; ex_is_load = 1; ex_wr_en = 1;
      id_rs = 5; id_use_rs_e = 1;
      @(negedge clk);
      chk("rst_busy", longint'(md_busy), 0);
      chk("rst_cnt", longint'(stall_cnt), 0);
      chk("rst_reg_stall", longint'(stall), 1);
      next();
      clr();
      id_is_md = 1; md_start = 1; md_is_div = 1;
      @(negedge clk);
      chk("rst_md_stall", longint'(stall), 0);
      next();
      clr();
      reset = 1'b1;
      next();

      // Load-use: lw $5 / add $6,$5,$1
      ex_wa = 5; ex_wr_en = 1; ex_is_load = 1;
      id_rs = 5; id_rt = 1; id_use_rs_e = 1; id_use_rt_e = 1;
      @(negedge clk);
      chk("lu_stall", longint'(stall), 1);
      chk("lu_bubble", longint'(bubble), 1);
      next();
      clr();
      mem_wa = 5; mem_is_load = 1;
      id_rs = 5; id_rt = 1; id_use_rs_e = 1; id_use_rt_e = 1;
      @(negedge clk);
      chk("lu_after", longint'(stall), 0);
      next();

      // Zero register never hazards
      clr();
      ex_wa = 0; ex_wr_en = 1; ex_is_load = 1;
      id_rs = 0; id_rt = 0; id_use_rs_d = 1; id_use_rs_e = 1;
      @(negedge clk);
      chk("zero_reg", longint'(stall), 0);
      next();

      // Branch after ALU: one stall
      clr();
      ex_wa = 3; ex_wr_en = 1;
      id_rs = 3; id_use_rs_d = 1;
      @(negedge clk);
      chk("br_alu_1", longint'(stall), 1);
      next();
      clr();
      mem_wa = 3; id_rs = 3; id_use_rs_d = 1;
      @(negedge clk);
      chk("br_alu_2", longint'(stall), 0);
      next();

      // Branch after load: two stalls
      clr();
      ex_wa = 3; ex_wr_en = 1; ex_is_load = 1;
      id_rt = 3; id_use_rt_d = 1;
      @(negedge clk);
      chk("br_ld_1", longint'(stall), 1);
      next();
      clr();
      mem_wa = 3; mem_is_load = 1; id_rt = 3; id_use_rt_d = 1;
      @(negedge clk);
      chk("br_ld_2", longint'(stall), 1);
      next();
      clr();
      id_rt = 3; id_use_rt_d = 1;
      @(negedge clk);
      chk("br_ld_3", longint'(stall), 0);
      next();
      clr();

      // MDU waits
      md_wait(1'b1, n);
      chk("div_wait", longint'(n), 11);
      md_wait(1'b0, n);
      chk("mult_wait", longint'(n), 6);

      // Reset mid-divide
      clr();
      md_start = 1; md_is_div = 1;
      next();
      md_start = 0;
      next();
      next();
      @(negedge clk);
      chk("div_busy_mid", longint'(md_busy), 1);
      #2 reset = 1'b0;
      #1 chk("abort_busy", longint'(md_busy), 0);
      next();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_abort", longint'(md_busy), 0);
         next();
      end

      // Stall counter: 4 load-use + 1 divide wait
      reset = 1'b0;
      next();
      reset = 1'b1;
      next();
      for (int i = 0; i < 4; i++) load_use_evt();
      md_wait(1'b1, n);
      @(negedge clk);
`ifdef PIPE_STALL_CNT_EN
      chk("cnt_total", longint'(stall_cnt), 15);
`else
      chk("cnt_total", longint'(stall_cnt), 0);
`endif
      next();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         id_use_rs_d = 1'($urandom);
         id_use_rt_d = 1'($urandom);
         id_use_rs_e = 1'($urandom);
         id_use_rt_e = 1'($urandom);
         id_is_md = ($urandom_range(0, 3) == 0);
         ex_wa = 5'($urandom_range(0, 3));
         ex_wr_en = 1'($urandom);
         ex_is_load = ($urandom_range(0, 3) == 0);
         mem_wa = 5'($urandom_range(0, 3));
         mem_is_load = ($urandom_range(0, 3) == 0);
         md_start = ($urandom_range(0, 7) == 0);
         md_is_div = 1'($urandom);
         next();
      end
      reset = 1'b1;
      clr();
      next();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
